// File: rtl/seq_shifter.sv
// seq_shifter: iterative one-bit-per-clock shift/rotate unit with start/done handshake
module seq_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] amt,
    input  logic [2:0]         S,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   H,
    output logic               Il,
    output logic               Ir
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [2:0] M_SHL = 3'b001, M_SHR = 3'b010, M_SAR = 3'b011, M_ROL = 3'b100, M_ROR = 3'b101;
    state_t             r_state;
    logic [2:0]         r_mode;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_h;
    logic               r_il, r_ir;
    logic [WIDTH-1:0]   w_next;
    logic               w_left, w_pass;
    always_comb begin
        w_left = (r_mode == M_SHL) || (r_mode == M_ROL);
        w_pass = (S == 3'b000) || (S[2:1] == 2'b11);
        w_next = (r_mode == M_SHL) ? {r_h[WIDTH-2:0], 1'b0} :
                 (r_mode == M_SHR) ? {1'b0, r_h[WIDTH-1:1]} :
                 (r_mode == M_SAR) ? {r_h[WIDTH-1], r_h[WIDTH-1:1]} :
                 (r_mode == M_ROL) ? {r_h[WIDTH-2:0], r_h[WIDTH-1]} :
                 (r_mode == M_ROR) ? {r_h[0], r_h[WIDTH-1:1]} : r_h;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= '0;
            r_cnt   <= '0;
            r_h     <= '0;
            r_il    <= 1'b0;
            r_ir    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_h     <= B;
                    r_il    <= 1'b0;
                    r_ir    <= 1'b0;
                    r_mode  <= S;
                    r_cnt   <= amt;
                    r_state <= (amt == '0 || w_pass) ? DONE : SHIFT;
                end
                SHIFT: begin
                    r_h   <= w_next;
                    r_cnt <= r_cnt - SHAMT_W'(1);
                    if (w_left) r_il <= r_h[WIDTH-1];
                    else r_ir <= r_h[0];
                    if (r_cnt == SHAMT_W'(1)) r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state == SHIFT);
    assign done     = (r_state == DONE);
    assign H        = r_h;
    assign Il       = r_il;
    assign Ir       = r_ir;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: randomized and directed checks of seq_shifter against an arithmetic shift model
module tb_seq_shifter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] B = '0;
    logic [3:0]  amt = '0;
    logic [2:0]  S = '0;
    logic        in_ready, busy, done, Il, Ir;
    logic [15:0] H;
    int vec = 0;
    int errs = 0;

    seq_shifter #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clock(clock), .reset(reset), .start(start), .B(B), .amt(amt), .S(S),
        .in_ready(in_ready), .busy(busy), .done(done), .H(H), .Il(Il), .Ir(Ir)
    );

    always #5 clock = ~clock;

    task automatic model(input logic [15:0] b, input logic [3:0] a, input logic [2:0] s,
                         output logic [15:0] h, output logic il, output logic ir);
        int n;
        logic signed [15:0] sb;
        n = a;
        sb = b;
        h = b; il = 1'b0; ir = 1'b0;
        if (n != 0) begin
            case (s)
                3'd1: begin h = b << n; il = b[16-n]; end
                3'd2: begin h = b >> n; ir = b[n-1]; end
                3'd3: begin h = sb >>> n; ir = b[n-1]; end
                3'd4: begin h = (b << n) | (b >> (16-n)); il = b[16-n]; end
                3'd5: begin h = (b >> n) | (b << (16-n)); ir = b[n-1]; end
                default: ;
            endcase
        end
    endtask

    task automatic do_op(input logic [15:0] b, input logic [3:0] a, input logic [2:0] s, input int inj);
        logic [15:0] eh;
        logic el, er;
        int n, lat, bcnt;
        model(b, a, s, eh, el, er);
        n = (s == 3'd0 || s >= 3'd6) ? 0 : int'(a);
        @(negedge clock);
        B = b; amt = a; S = s; start = 1'b1;
        @(negedge clock);
        start = 1'b0; B = 16'($urandom); amt = 4'($urandom); S = 3'($urandom);
        lat = -1; bcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin lat = c; break; end
            if (busy) bcnt++;
            start = (c == inj);
            @(negedge clock);
        end
        start = 1'b0;
        vec++;
        if (lat !== n) begin errs++; $display("FAIL latency s=%0d amt=%0d: got %0d want %0d", s, a, lat, n); end
        vec++;
        if (bcnt !== n) begin errs++; $display("FAIL busy_cycles s=%0d amt=%0d: got %0d want %0d", s, a, bcnt, n); end
        vec++;
        if (H !== eh) begin errs++; $display("FAIL H s=%0d b=%h amt=%0d: got %h want %h", s, b, a, H, eh); end
        vec++;
        if (Il !== el || Ir !== er) begin errs++; $display("FAIL IlIr s=%0d b=%h amt=%0d: got %b%b want %b%b", s, b, a, Il, Ir, el, er); end
        @(negedge clock);
        vec++;
        if (done !== 1'b0 || in_ready !== 1'b1 || H !== eh) begin
            errs++; $display("FAIL after_done: done=%b in_ready=%b H=%h want 0 1 %h", done, in_ready, H, eh);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; B = 16'hFFFF; amt = 4'd3; S = 3'd1;
        repeat (2) begin
            @(negedge clock);
            vec++;
            if (H !== 16'h0 || Il !== 1'b0 || Ir !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errs++; $display("FAIL reset: H=%h Il=%b Ir=%b done=%b busy=%b rdy=%b want 0 0 0 0 0 1", H, Il, Ir, done, busy, in_ready);
            end
        end
        start = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clock);
        vec++;
        if (in_ready !== 1'b1 || H !== 16'h0) begin errs++; $display("FAIL idle_hold: rdy=%b H=%h want 1 0000", in_ready, H); end
    endtask

    task automatic test_directed();
        do_op(16'h8001, 4'd1, 3'd1, -1);
        do_op(16'h8000, 4'd4, 3'd3, -1);
        do_op(16'h8000, 4'd4, 3'd2, -1);
        do_op(16'h000F, 4'd3, 3'd2, -1);
        do_op(16'h0001, 4'd1, 3'd5, -1);
        do_op(16'h8421, 4'd15, 3'd4, -1);
        vec++;
        if (H !== 16'hC210) begin errs++; $display("FAIL rol15_const: got %h want c210", H); end
    endtask

    task automatic test_pass_zero();
        do_op(16'hA5A5, 4'd7, 3'd0, -1);
        do_op(16'h5A5A, 4'd0, 3'd1, -1);
        do_op(16'h1234, 4'd9, 3'd6, -1);
        do_op(16'h4321, 4'd2, 3'd7, -1);
    endtask

    task automatic test_ignore_start();
        do_op(16'h00F1, 4'd8, 3'd1, 2);
        do_op(16'hBEEF, 4'd12, 3'd5, 0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        B = 16'hFFFF; amt = 4'd10; S = 3'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (done) seen = 1'b1;
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        vec++;
        if (H !== 16'h0 || Il !== 1'b0 || Ir !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL reset_mid: H=%h Il=%b Ir=%b rdy=%b busy=%b done=%b", H, Il, Ir, in_ready, busy, done);
        end
        repeat (12) begin
            if (done) seen = 1'b1;
            @(negedge clock);
        end
        vec++;
        if (seen) begin errs++; $display("FAIL reset_mid_done: got pulse want none"); end
        do_op(16'h0F0F, 4'd10, 3'd1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            logic [3:0] a;
            a = 4'($urandom);
            do_op(16'($urandom), a, 3'($urandom), (a > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, a - 1)) : -1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_pass_zero();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
